// File: rtl/router_pkg.sv
// Shared constants and state encoding for the router ingress controller.
package router_pkg;

    localparam int unsigned DW_DEFAULT        = 8;
    localparam int unsigned NUM_PORTS_DEFAULT = 3;
    localparam logic [1:0]  ADDR_INVALID      = 2'b11;
    localparam int unsigned TIMEOUT_CYCLES    = 30;

    typedef logic [2:0] state_t;

    localparam state_t DECODE          = 3'd0;
    localparam state_t WAIT_EMPTY      = 3'd1;
    localparam state_t LOAD_FIRST      = 3'd2;
    localparam state_t LOAD_DATA       = 3'd3;
    localparam state_t FULL_STATE      = 3'd4;
    localparam state_t LOAD_AFTER_FULL = 3'd5;
    localparam state_t LOAD_PARITY     = 3'd6;
    localparam state_t DROP            = 3'd7;

endpackage

// File: rtl/router_ingress_ctrl_if.sv
// Byte-stream source, FIFO status and FIFO write bundle of the router ingress stage.
interface router_ingress_ctrl_if import router_pkg::*; #(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEFAULT
) ();

    logic                 pkt_valid;
    logic [DW-1:0]        data_in;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] read_enb;
    logic                 busy;
    logic [NUM_PORTS-1:0] write_enb;
    logic                 lfd_state;
    logic [DW-1:0]        dout;
    logic                 err;
    logic [NUM_PORTS-1:0] soft_reset;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        output busy, write_enb, lfd_state, dout, err, soft_reset
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
        input  busy, write_enb, lfd_state, dout, err, soft_reset
    );

endinterface

// File: rtl/router_timeout.sv
// Per-FIFO idle-read watchdog: pulses soft_reset_o after TIMEOUT_CYCLES unread, non-empty cycles.
module router_timeout import router_pkg::*; (
    input  logic clk,
    input  logic reset,
    input  logic fifo_empty_i,
    input  logic read_enb_i,
    output logic soft_reset_o
);

    logic [4:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (fifo_empty_i || read_enb_i) begin
            cnt_d = '0;
        end else if (cnt_q == 5'(TIMEOUT_CYCLES - 1)) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset_o = pulse_q;

endmodule

// File: rtl/router_ingress_ctrl.sv
// Router ingress FSM: header decode, FIFO write steering, source throttling and parity check.
// Optional watchdog soft reset enabled by ROUTER_SOFT_TIMEOUT_EN.
module router_ingress_ctrl import router_pkg::*; #(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    router_ingress_ctrl_if.slave bus_io
);

    state_t               state_q, state_d;
    logic [1:0]           dest_q, dest_d;
    logic [DW-1:0]        parity_q, parity_d;
    logic [DW-1:0]        pbyte_q, pbyte_d;
    logic [DW-1:0]        hold_q, hold_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic [NUM_PORTS-1:0] wen_q, wen_d;
    logic                 lfd_q, lfd_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] hdr_oh, dest_oh, soft_reset;
    logic                 hdr_empty, dest_empty, dest_full, dest_srst;

    always_comb begin
        hdr_oh  = '0;
        dest_oh = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            hdr_oh[i]  = (32'(bus_io.data_in[1:0]) == i);
            dest_oh[i] = (32'(dest_q) == i);
        end
    end

    assign hdr_empty  = |(bus_io.fifo_empty & hdr_oh);
    assign dest_empty = |(bus_io.fifo_empty & dest_oh);
    assign dest_full  = |(bus_io.fifo_full & dest_oh);
    assign dest_srst  = |(soft_reset & dest_oh);

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        parity_d = parity_q;
        pbyte_d  = pbyte_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        wen_d    = '0;
        lfd_d    = 1'b0;
        err_d    = err_q;

        case (state_q)
            DECODE: begin
                if (bus_io.pkt_valid) begin
                    if (bus_io.data_in[1:0] == ADDR_INVALID) begin
                        state_d = DROP;
                    end else begin
                        dest_d = bus_io.data_in[1:0];
                        if (hdr_empty) begin
                            parity_d = bus_io.data_in;
                            dout_d   = bus_io.data_in;
                            wen_d    = hdr_oh;
                            lfd_d    = 1'b1;
                            state_d  = LOAD_FIRST;
                        end else begin
                            state_d = WAIT_EMPTY;
                        end
                    end
                end
            end
            WAIT_EMPTY: begin
                if (dest_empty) begin
                    parity_d = bus_io.data_in;
                    dout_d   = bus_io.data_in;
                    wen_d    = dest_oh;
                    lfd_d    = 1'b1;
                    state_d  = LOAD_FIRST;
                end
            end
            LOAD_FIRST: begin
                err_d   = 1'b0;
                state_d = LOAD_DATA;
            end
            LOAD_DATA: begin
                // Parity byte needs no FIFO space, so pkt_valid low wins over full.
                if (!bus_io.pkt_valid) begin
                    pbyte_d = bus_io.data_in;
                    state_d = LOAD_PARITY;
                end else if (dest_full) begin
                    hold_d  = bus_io.data_in;
                    state_d = FULL_STATE;
                end else begin
                    parity_d = parity_q ^ bus_io.data_in;
                    dout_d   = bus_io.data_in;
                    wen_d    = dest_oh;
                end
            end
            FULL_STATE: begin
                if (!dest_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                parity_d = parity_q ^ hold_q;
                dout_d   = hold_q;
                wen_d    = dest_oh;
                state_d  = LOAD_DATA;
            end
            LOAD_PARITY: begin
                err_d   = (pbyte_q != parity_q);
                state_d = DECODE;
            end
            DROP: begin
                if (!bus_io.pkt_valid) begin
                    state_d = DECODE;
                end
            end
            default: state_d = DECODE;
        endcase

        // A soft reset of the target FIFO abandons the packet without further writes.
        if (state_q != DECODE && state_q != DROP && dest_srst) begin
            state_d = bus_io.pkt_valid ? DROP : DECODE;
            wen_d   = '0;
            lfd_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= DECODE;
            dest_q   <= '0;
            parity_q <= '0;
            pbyte_q  <= '0;
            hold_q   <= '0;
            dout_q   <= '0;
            wen_q    <= '0;
            lfd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            parity_q <= parity_d;
            pbyte_q  <= pbyte_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            wen_q    <= wen_d;
            lfd_q    <= lfd_d;
            err_q    <= err_d;
        end
    end

`ifdef ROUTER_SOFT_TIMEOUT_EN
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
        router_timeout u_timeout (
            .clk          (clk),
            .reset        (reset),
            .fifo_empty_i (bus_io.fifo_empty[i]),
            .read_enb_i   (bus_io.read_enb[i]),
            .soft_reset_o (soft_reset[i])
        );
    end
`else
    logic unused_read_enb;
    assign unused_read_enb = ^bus_io.read_enb;
    assign soft_reset      = '0;
`endif

    assign bus_io.busy       = (state_q == WAIT_EMPTY) || (state_q == LOAD_FIRST) ||
                               (state_q == FULL_STATE) || (state_q == LOAD_AFTER_FULL) ||
                               (state_q == LOAD_PARITY);
    assign bus_io.write_enb  = wen_q;
    assign bus_io.lfd_state  = lfd_q;
    assign bus_io.dout       = dout_q;
    assign bus_io.err        = err_q;
    assign bus_io.soft_reset = soft_reset;

endmodule

// File: doc/router_ingress_ctrl.md
Name: router_ingress_ctrl

Overview:
Ingress stage of the 1x3 router, sitting directly upstream of the three per-port output FIFOs.
- Accepts the serial byte stream: header, payload bytes, then parity byte.
- Decodes the destination port from the header and drives that FIFO's write enable, data and header marker (lfd_state).
- Throttles the source with busy and checks packet parity.

Parameters:
DW, 8, data byte width
NUM_PORTS, 3, number of output FIFOs (destination codes 0..2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pkt_valid  input  1  high for header and payload bytes; low on the parity byte
data_in  input  DW  byte stream; header bits [1:0] = destination, [7:2] = payload length
fifo_full  input  NUM_PORTS  full flag per FIFO
fifo_empty  input  NUM_PORTS  empty flag per FIFO
read_enb  input  NUM_PORTS  downstream read enables (used only by the timeout feature)
busy  output  1  source must hold data_in/pkt_valid stable while high
write_enb  output  NUM_PORTS  one-hot write strobe to the selected FIFO
lfd_state  output  1  high in the cycle the header byte is written
dout  output  DW  registered byte to FIFOs; aligned with write_enb
err  output  1  parity mismatch flag for the last packet
soft_reset  output  NUM_PORTS  per-FIFO soft reset pulse

Behaviour:
- Reset: all outputs are 0 and the state is DECODE. Internal parity and destination registers are cleared. Reset acts immediately and asynchronously, and aborts any packet in progress.
- Latency: data_in is registered into dout in the cycle its byte is accepted. write_enb and lfd_state are asserted in the cycle after acceptance, together with that dout.
- DECODE (busy=0):
  - pkt_valid=1 and data_in[1:0]==3 -> DROP.
  - pkt_valid=1 and fifo_empty[dest]=1 -> latch dest, load parity accumulator with header -> LOAD_FIRST.
  - pkt_valid=1 and fifo_empty[dest]=0 -> latch dest -> WAIT_EMPTY.
- WAIT_EMPTY (busy=1): when fifo_empty[dest]=1 -> accept header -> LOAD_FIRST.
- LOAD_FIRST (busy=1): write header (write_enb[dest]=1, lfd_state=1), clear err -> LOAD_DATA.
- LOAD_DATA (busy=0):
  - Each cycle with pkt_valid=1 and fifo_full[dest]=0: accept byte, XOR it into parity, write it next cycle.
  - pkt_valid=1 and fifo_full[dest]=1: no write -> FULL_STATE.
  - pkt_valid=0: the current byte is the parity byte; latch it -> LOAD_PARITY.
- FULL_STATE (busy=1): write_enb=0. When fifo_full[dest]=0 -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL (busy=1): accept the held byte and XOR it into parity -> LOAD_DATA.
- LOAD_PARITY (busy=1):
  - Parity byte is not written to the FIFO.
  - Compare against the accumulator; err=1 on mismatch -> DECODE.
  - err holds until the next LOAD_FIRST or reset.
- DROP (busy=0): discard bytes until pkt_valid=0; that cycle's byte (parity) is also discarded -> DECODE. No write_enb is asserted.
- Simultaneous events:
  - fifo_full and pkt_valid falling in the same cycle: the parity byte does not need FIFO space, so go to LOAD_PARITY.
  - soft_reset[dest] asserted in any state other than DECODE/DROP: go to DROP next cycle if pkt_valid=1, else to DECODE. No further writes.
- At most one write_enb bit is high at any time.
- Payload length field is not checked; pkt_valid is the only framing signal.

Optional Feature:
ROUTER_SOFT_TIMEOUT_EN:
- Defined:
  - Per port, a 5-bit counter increments while fifo_empty[i]=0 and read_enb[i]=0.
  - It clears when read_enb[i]=1 or fifo_empty[i]=1.
  - On reaching 30, soft_reset[i] pulses high for one cycle and the counter clears.
- Undefined: soft_reset is tied to 0 and read_enb is unused.

Decomposition:
- Package router_pkg holds:
  - the state enum (DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, DROP);
  - DW and NUM_PORTS defaults;
  - ADDR_INVALID=2'b11;
  - TIMEOUT_CYCLES=30.
- Sub-module router_timeout holds one counter and one pulse per port, instantiated NUM_PORTS times under the macro.

Test Plan:
- Header 8'h0D (dest 1, len 3), payload 11,22,33, parity = XOR of all four bytes; FIFO1 empty -> write_enb=3'b010 for 4 cycles, lfd_state on the first only, err=0.
- Same packet with parity byte corrupted (XOR ^ 8'h01) -> err=1 after LOAD_PARITY, cleared on the next header write.
- Header 8'h02 while fifo_empty[2]=0 -> busy=1, no writes, until fifo_empty[2]=1, then the header is written with lfd_state=1.
- fifo_full[0] rises mid-payload for 3 cycles -> busy=1, write_enb=0 during stall; the held byte is written once after the stall with no loss or duplication.
- Header 8'h07 (dest 3) plus 2 bytes plus parity -> no write_enb, busy=0 throughout, back to DECODE.
- With ROUTER_SOFT_TIMEOUT_EN: fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1] pulses once. Reset asserted mid-payload -> all outputs 0 immediately.
